piece_sequencer: RTL

//  Chooses the tetromino type for every spawn in the 10x10 VGA Tetris. Drives

---
 rtl/piece_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/piece_sequencer.sv
// piece_sequencer: picks tetromino types for each spawn. Keeps one current
// piece and one preview piece, drawn from a free-running LFSR with rejection
// sampling and a bounded reroll count, and serves spawns via req/ack.
module piece_sequencer #(
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         NUM_TYPES  = 5,
    parameter int         MAX_REROLL = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spawn_req,
    output logic       spawn_ack,
    output logic [2:0] block_type,
    output logic [2:0] next_type,
    output logic       seq_valid
);

    // Reroll counter only needs to reach MAX_REROLL-1.
    localparam int             RW       = (MAX_REROLL > 1) ? $clog2(MAX_REROLL) : 1;
    localparam logic [RW-1:0]  RR_LAST  = RW'(MAX_REROLL - 1);
    localparam logic [3:0]     NT       = 4'(NUM_TYPES);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0]     SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {FILL0, FILL1, READY, DRAW} state_t;

    state_t        state_q;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [RW-1:0] reroll_q, reroll_d;
    logic [2:0]    block_q, next_q;
    logic          valid_q, ack_q;
    logic          draw_hit;
    logic [2:0]    draw_val;

    // Next LFSR value and the outcome of a draw on the current LFSR value.
    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        draw_hit = 1'b1;
        draw_val = lfsr_q[2:0];
        reroll_d = '0;
        if ({1'b0, lfsr_q[2:0]} >= NT) begin
            if (reroll_q == RR_LAST) begin
                // Out of rerolls: force the fallback type so a draw is bounded.
                draw_val = 3'd0;
            end else begin
                draw_hit = 1'b0;
                reroll_d = reroll_q + RW'(1);
            end
        end
    end

    // Fill / ready / draw sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL0;
            lfsr_q   <= SEED_EFF;
            reroll_q <= '0;
            block_q  <= 3'd0;
            next_q   <= 3'd0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            ack_q  <= 1'b0;
            case (state_q)
                FILL0: begin
                    reroll_q <= reroll_d;
                    if (draw_hit) begin
                        block_q <= draw_val;
                        state_q <= FILL1;
                    end
                end
                FILL1: begin
                    reroll_q <= reroll_d;
                    if (draw_hit) begin
                        next_q  <= draw_val;
                        valid_q <= 1'b1;
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (spawn_req) begin
                        block_q <= next_q;
                        ack_q   <= 1'b1;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    // Requests wait here; req is a level so nothing is lost.
                    reroll_q <= reroll_d;
                    if (draw_hit) begin
                        next_q  <= draw_val;
                        state_q <= READY;
                    end
                end
                default: state_q <= FILL0;
            endcase
        end
    end

    assign spawn_ack  = ack_q;
    assign block_type = block_q;
    assign next_type  = next_q;
    assign seq_valid  = valid_q;

endmodule
